// File: rtl/pwm_halfbridge_monitor.sv
// Half-bridge gate monitor: measures per-period on-times, deadtimes and both-off time
// of the highside/lowside gate signals and flags shoot-through and runt pulses.
module pwm_halfbridge_monitor #(
    parameter int tick_count_period      = 100,
    parameter int bitwidth               = $clog2(tick_count_period) + 1,
    parameter int minimum_driver_on_time = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [bitwidth-1:0] tick_counter,
    input  logic                highside_input,
    input  logic                lowside_input,
    input  logic                clear_errors,
    output logic [bitwidth-1:0] measured_tick_count_highside,
    output logic [bitwidth-1:0] measured_tick_count_lowside,
    output logic [bitwidth-1:0] measured_deadtime_hs_to_ls,
    output logic [bitwidth-1:0] measured_deadtime_ls_to_hs,
    output logic [bitwidth-1:0] measured_both_gates_off,
    output logic                measurement_valid,
    output logic                shortcircuit_error,
    output logic                pulse_too_short_error,
    output logic                debug_state
);

    typedef enum logic {
        STATE_WAIT_SYNC = 1'b0,
        STATE_MEASURE   = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        LAST_NONE = 2'd0,
        LAST_HS   = 2'd1,
        LAST_LS   = 2'd2
    } last_on_t;

    localparam logic [bitwidth-1:0] last_tick = bitwidth'(tick_count_period - 1);
    localparam logic [bitwidth-1:0] min_on    = bitwidth'(minimum_driver_on_time);

    function automatic logic [bitwidth-1:0] sat_inc(input logic [bitwidth-1:0] v);
        return (v == {bitwidth{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Stage-1 samples: gates and counter registered together so they stay aligned.
    logic                hs_s_q, hs_s_d, ls_s_q, ls_s_d;
    logic [bitwidth-1:0] tick_s_q, tick_s_d;

    state_t              state_q, state_d;
    last_on_t            last_on_q, last_on_d;

    logic [bitwidth-1:0] hs_acc_q, hs_acc_d, ls_acc_q, ls_acc_d;
    logic [bitwidth-1:0] h2l_acc_q, h2l_acc_d, l2h_acc_q, l2h_acc_d;
    logic [bitwidth-1:0] off_acc_q, off_acc_d;
    logic [bitwidth-1:0] hs_run_q, hs_run_d, ls_run_q, ls_run_d;

    logic [bitwidth-1:0] meas_hs_q, meas_hs_d, meas_ls_q, meas_ls_d;
    logic [bitwidth-1:0] meas_h2l_q, meas_h2l_d, meas_l2h_q, meas_l2h_d;
    logic [bitwidth-1:0] meas_off_q, meas_off_d;
    logic                valid_q, valid_d;
    logic                sc_err_q, sc_err_d, short_err_q, short_err_d;

    logic [bitwidth-1:0] hs_acc_n, ls_acc_n, h2l_acc_n, l2h_acc_n, off_acc_n;
    logic                both_off, period_end, sc_set, short_set;

    always_comb begin
        hs_s_d      = highside_input;
        ls_s_d      = lowside_input;
        tick_s_d    = tick_counter;
        state_d     = state_q;
        last_on_d   = last_on_q;
        hs_acc_d    = hs_acc_q;
        ls_acc_d    = ls_acc_q;
        h2l_acc_d   = h2l_acc_q;
        l2h_acc_d   = l2h_acc_q;
        off_acc_d   = off_acc_q;
        meas_hs_d   = meas_hs_q;
        meas_ls_d   = meas_ls_q;
        meas_h2l_d  = meas_h2l_q;
        meas_l2h_d  = meas_l2h_q;
        meas_off_d  = meas_off_q;
        valid_d     = 1'b0;

        both_off    = ~hs_s_q & ~ls_s_q;
        period_end  = (tick_s_q == last_tick);
        hs_acc_n    = hs_s_q ? sat_inc(hs_acc_q) : hs_acc_q;
        ls_acc_n    = ls_s_q ? sat_inc(ls_acc_q) : ls_acc_q;
        off_acc_n   = both_off ? sat_inc(off_acc_q) : off_acc_q;
        h2l_acc_n   = (both_off && last_on_q == LAST_HS) ? sat_inc(h2l_acc_q) : h2l_acc_q;
        l2h_acc_n   = (both_off && last_on_q == LAST_LS) ? sat_inc(l2h_acc_q) : l2h_acc_q;

        // A nonzero run counter means the previous sample was high, so a low
        // sample here closes a pulse of exactly run_q ticks.
        hs_run_d    = hs_s_q ? sat_inc(hs_run_q) : '0;
        ls_run_d    = ls_s_q ? sat_inc(ls_run_q) : '0;
        short_set   = (!hs_s_q && hs_run_q != '0 && hs_run_q < min_on) ||
                      (!ls_s_q && ls_run_q != '0 && ls_run_q < min_on);
        sc_set      = hs_s_q & ls_s_q;

        case (state_q)
            STATE_WAIT_SYNC: begin
                if (period_end) begin
                    state_d   = STATE_MEASURE;
                    hs_acc_d  = '0;
                    ls_acc_d  = '0;
                    h2l_acc_d = '0;
                    l2h_acc_d = '0;
                    off_acc_d = '0;
                end
            end
            STATE_MEASURE: begin
                if (hs_s_q && !ls_s_q) begin
                    last_on_d = LAST_HS;
                end else if (!hs_s_q && ls_s_q) begin
                    last_on_d = LAST_LS;
                end
                // measurement_valid is a one-cycle strobe without back-pressure;
                // measured_* are stable from the strobe until the next one.
                if (period_end) begin
                    meas_hs_d  = hs_acc_n;
                    meas_ls_d  = ls_acc_n;
                    meas_h2l_d = h2l_acc_n;
                    meas_l2h_d = l2h_acc_n;
                    meas_off_d = off_acc_n;
                    valid_d    = 1'b1;
                    hs_acc_d   = '0;
                    ls_acc_d   = '0;
                    h2l_acc_d  = '0;
                    l2h_acc_d  = '0;
                    off_acc_d  = '0;
                end else begin
                    hs_acc_d   = hs_acc_n;
                    ls_acc_d   = ls_acc_n;
                    h2l_acc_d  = h2l_acc_n;
                    l2h_acc_d  = l2h_acc_n;
                    off_acc_d  = off_acc_n;
                end
            end
            default: state_d = STATE_WAIT_SYNC;
        endcase

        sc_err_d    = sc_set ? 1'b1 : (clear_errors ? 1'b0 : sc_err_q);
        short_err_d = short_set ? 1'b1 : (clear_errors ? 1'b0 : short_err_q);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            hs_s_q      <= 1'b0;
            ls_s_q      <= 1'b0;
            tick_s_q    <= '0;
            state_q     <= STATE_WAIT_SYNC;
            last_on_q   <= LAST_NONE;
            hs_acc_q    <= '0;
            ls_acc_q    <= '0;
            h2l_acc_q   <= '0;
            l2h_acc_q   <= '0;
            off_acc_q   <= '0;
            hs_run_q    <= '0;
            ls_run_q    <= '0;
            meas_hs_q   <= '0;
            meas_ls_q   <= '0;
            meas_h2l_q  <= '0;
            meas_l2h_q  <= '0;
            meas_off_q  <= '0;
            valid_q     <= 1'b0;
            sc_err_q    <= 1'b0;
            short_err_q <= 1'b0;
        end else begin
            hs_s_q      <= hs_s_d;
            ls_s_q      <= ls_s_d;
            tick_s_q    <= tick_s_d;
            state_q     <= state_d;
            last_on_q   <= last_on_d;
            hs_acc_q    <= hs_acc_d;
            ls_acc_q    <= ls_acc_d;
            h2l_acc_q   <= h2l_acc_d;
            l2h_acc_q   <= l2h_acc_d;
            off_acc_q   <= off_acc_d;
            hs_run_q    <= hs_run_d;
            ls_run_q    <= ls_run_d;
            meas_hs_q   <= meas_hs_d;
            meas_ls_q   <= meas_ls_d;
            meas_h2l_q  <= meas_h2l_d;
            meas_l2h_q  <= meas_l2h_d;
            meas_off_q  <= meas_off_d;
            valid_q     <= valid_d;
            sc_err_q    <= sc_err_d;
            short_err_q <= short_err_d;
        end
    end

    assign measured_tick_count_highside = meas_hs_q;
    assign measured_tick_count_lowside  = meas_ls_q;
    assign measured_deadtime_hs_to_ls   = meas_h2l_q;
    assign measured_deadtime_ls_to_hs   = meas_l2h_q;
    assign measured_both_gates_off      = meas_off_q;
    assign measurement_valid            = valid_q;
    assign shortcircuit_error           = sc_err_q;
    assign pulse_too_short_error        = short_err_q;
    assign debug_state                  = state_q;

endmodule

// File: doc/pwm_halfbridge_monitor.md
Name: pwm_halfbridge_monitor

Overview:
- Monitors one half bridge from the receiving side: samples the highside and lowside gate signals generated by the half-bridge PWM block.
- Measures, per PWM period, the on-time of each gate, both deadtimes and the total both-off time, against the shared period tick counter.
- Publishes the results with a one-cycle valid strobe and raises sticky shoot-through and runt-pulse flags.
- Sits beside the PWM generator: it closes the loop for self-test, DCM supervision and gate-driver fault detection.

Parameters:
- tick_count_period, 100, ticks per PWM period; the period ends at tick_counter == tick_count_period-1.
- bitwidth, $clog2(tick_count_period)+1, width of tick_counter and of every measurement output.
- minimum_driver_on_time, 8, shortest legal high pulse, in ticks, on either gate.

Ports:
- clock, input, 1, system clock; all logic on the rising edge.
- reset, input, 1, synchronous, active-low; 0 sampled on a rising edge resets the block.
- tick_counter, input, bitwidth, shared period counter (0..tick_count_period-1).
- highside_input, input, 1, highside gate signal (same clock domain).
- lowside_input, input, 1, lowside gate signal (same clock domain).
- clear_errors, input, 1, level; clears the sticky error flags.
- measured_tick_count_highside, output, bitwidth, highside high ticks in the last complete period.
- measured_tick_count_lowside, output, bitwidth, lowside high ticks in the last complete period.
- measured_deadtime_hs_to_ls, output, bitwidth, both-off ticks following a highside on-phase.
- measured_deadtime_ls_to_hs, output, bitwidth, both-off ticks following a lowside on-phase.
- measured_both_gates_off, output, bitwidth, total both-off ticks.
- measurement_valid, output, 1, one-cycle strobe when the measured_* outputs update.
- shortcircuit_error, output, 1, sticky: both gates were sampled high on the same tick.
- pulse_too_short_error, output, 1, sticky: a completed high pulse was shorter than minimum_driver_on_time.

Behaviour:
- Reset (reset == 0 on an edge): all outputs 0, all accumulators 0, last_on = NONE, run counters 0, state = STATE_WAIT_SYNC. Reset has priority over every other action.
- Stage 1: highside_input, lowside_input and tick_counter are registered together. All counting uses these stage-1 samples, so inputs and counter stay aligned.
- STATE_WAIT_SYNC: no accumulation and no measurement_valid.
  - A stage-1 sample with tick_counter == tick_count_period-1 moves the state to STATE_MEASURE with accumulators at 0.
  - This discards the partial period that was in progress when reset released.
- STATE_MEASURE, on each edge, using the stage-1 sample:
  - hs sample = 1: highside accumulator +1.
  - ls sample = 1: lowside accumulator +1.
  - Both samples = 0: both_off accumulator +1. In addition, the hs_to_ls accumulator +1 if last_on == HS, or the ls_to_hs accumulator +1 if last_on == LS; neither if last_on == NONE.
  - last_on becomes HS when only hs is high, LS when only ls is high, and is unchanged otherwise.
  - last_on persists across period boundaries. In DCM the idle interval therefore counts toward the deadtime of the preceding side.
- Period end: when the stage-1 sample has tick_counter == tick_count_period-1, on that same edge:
  - The accumulator values plus the current sample are loaded into the measured_* outputs.
  - measurement_valid is set to 1 for exactly one cycle.
  - All accumulators are cleared to 0.
- Latency: tick_counter == tick_count_period-1 at the input in cycle k gives measurement_valid = 1 in cycle k+2. The measured_* outputs hold their value until the next strobe.
- Width: accumulators are bitwidth wide and saturate at 2^bitwidth-1 (no wrap). Per period, hs + ls + both_off == tick_count_period unless a shoot-through tick occurred.
- Shoot-through: a sample with both gates high counts in both the highside and lowside accumulators, sets shortcircuit_error, and leaves last_on unchanged.
- Pulse length:
  - One run counter per gate: incremented (saturating) while the sample is high, cleared when it is low. Run counters span period boundaries and are active in both states.
  - On a falling sample (previous 1, current 0), if the run counter < minimum_driver_on_time, pulse_too_short_error is set.
  - A gate held high permanently (flat top) never raises this error.
- Error flags: set and clear on the same edge resolves to set. clear_errors == 1 clears a flag only when no new set condition occurs on that edge.
- Reset mid-period: the block returns to STATE_WAIT_SYNC; no strobe is issued for the interrupted period.

Test Plan:
- Regular PWM (hs ticks 0..39, 12-tick deadtime, ls ticks 52..87, 12 off) -> second and later strobes: hs = 40, ls = 36, hs_to_ls = 12, ls_to_hs = 12, both_off = 24; no errors.
- reset released at tick_counter = 50 -> no strobe in that period. First strobe arrives 2 cycles after the next tick 99 and reports full-period values.
- Flat-top highside (hs constantly 1, ls 0) -> hs = 100, ls = 0, deadtimes = 0, both_off = 0; pulse_too_short_error stays 0.
- 5-tick highside pulse -> pulse_too_short_error = 1 after the falling sample. Repeating with an 8-tick pulse after clear_errors -> flag stays 0.
- One tick with both gates high -> shortcircuit_error = 1 and sticky. clear_errors = 1 on a later overlap-free cycle clears it; clear_errors asserted on an overlap tick -> flag stays 1.
- DCM (hs 30, 12 off, ls 20, rest off) -> hs = 30, ls = 20, hs_to_ls = 12, ls_to_hs = 38, both_off = 50.
